// File: rtl/fetch_aligner_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_aligner_pkg : shared core constants, fetch FSM states         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_aligner_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [6:0]  OPC_OP_IMM  = 7'b001_0011;
    localparam logic [6:0]  OPC_OP      = 7'b011_0011;
    localparam logic [6:0]  OPC_LUI     = 7'b011_0111;
    localparam logic [6:0]  OPC_BRANCH  = 7'b110_0011;
    localparam logic [6:0]  OPC_JAL     = 7'b110_1111;
    localparam logic [6:0]  OPC_JALR    = 7'b110_0111;
    localparam logic [6:0]  OPC_LOAD    = 7'b000_0011;
    localparam logic [6:0]  OPC_STORE   = 7'b010_0011;

    localparam logic [15:0] C_NOP       = 16'h0001;
    localparam logic [1:0]  C_QUAD0     = 2'b00;
    localparam logic [1:0]  C_QUAD1     = 2'b01;
    localparam logic [1:0]  C_QUAD2     = 2'b10;
    localparam logic [1:0]  QUAD_FULL32 = 2'b11;

    function automatic logic is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != QUAD_FULL32;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_aligner_if.sv
// +--------------------------------------------------------------------+
// | fetch_aligner_if : memory, redirect and instruction-output bundle   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface fetch_aligner_if;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Valid;
    logic [31:0] Mem_Rdata;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Stall;
    logic [31:0] Inst_Out;
    logic        Inst_Valid;
    logic [31:0] Inst_PC;
    logic        Inst_Compr;

    modport master (
        output Mem_Req, Mem_Addr, Inst_Out, Inst_Valid, Inst_PC, Inst_Compr,
        input  Mem_Valid, Mem_Rdata, Redirect, Redirect_PC, Stall
    );

    modport slave (
        input  Mem_Req, Mem_Addr, Inst_Out, Inst_Valid, Inst_PC, Inst_Compr,
        output Mem_Valid, Mem_Rdata, Redirect, Redirect_PC, Stall
    );
endinterface

`default_nettype wire

// File: rtl/fetch_aligner.sv
// +--------------------------------------------------------------------+
// | fetch_aligner : word fetch into a 3-halfword queue, emits 16/32-bit |
// | instruction parcels with their PC. Rev 1.0                          |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fetch_aligner_if.master bus
);

    fetch_state_e state, state_next;

    // queue holds {hw2, hw1, hw0}; hw0 is the oldest halfword
    logic [47:0] queue, queue_next;
    logic [1:0]  count, count_next;
    logic [31:0] inst_pc, inst_pc_next;
    logic [29:0] fetch_word, fetch_word_next;
    logic        skip_half, skip_half_next;

    logic [15:0] hw0, hw1;
    logic        compr;
    logic        inst_valid;
    logic        consume;
    logic        mem_req;
    logic        append;
    logic [1:0]  popped;
    logic [1:0]  remaining;
    logic [1:0]  appended;
    logic [47:0] shifted;

    assign hw0        = queue[15:0];
    assign hw1        = queue[31:16];
    assign compr      = is_compressed(hw0);
    assign inst_valid = !rst && !bus.Redirect &&
                        ((count >= 2'd2) || ((count == 2'd1) && compr));
    assign consume    = inst_valid && !bus.Stall;
    assign popped     = consume ? (compr ? 2'd1 : 2'd2) : 2'd0;
    assign remaining  = count - popped;
    // the queue can take a whole word only once at most one halfword survives this cycle
    assign mem_req    = (state == ST_FETCH) && !rst && !bus.Redirect && (remaining <= 2'd1);
    assign append     = (state == ST_WAIT) && bus.Mem_Valid && !bus.Redirect;
    assign appended   = append ? (skip_half ? 2'd1 : 2'd2) : 2'd0;
    assign shifted    = queue >> {popped, 4'b0000};

    assign bus.Mem_Req    = mem_req;
    assign bus.Mem_Addr   = {fetch_word, 2'b00};
    assign bus.Inst_Out   = compr ? {16'h0000, hw0} : {hw1, hw0};
    assign bus.Inst_Valid = inst_valid;
    assign bus.Inst_PC    = inst_pc;
    assign bus.Inst_Compr = compr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            queue      <= '0;
            count      <= 2'd0;
            inst_pc    <= RESET_PC;
            fetch_word <= RESET_PC[31:2];
            skip_half  <= RESET_PC[1];
        end else begin
            state      <= state_next;
            queue      <= queue_next;
            count      <= count_next;
            inst_pc    <= inst_pc_next;
            fetch_word <= fetch_word_next;
            skip_half  <= skip_half_next;
        end
    end

    always_comb begin
        state_next      = state;
        queue_next      = queue;
        count_next      = count;
        inst_pc_next    = inst_pc;
        fetch_word_next = fetch_word;
        skip_half_next  = skip_half;

        if (bus.Redirect) begin
            count_next      = 2'd0;
            inst_pc_next    = {bus.Redirect_PC[31:1], 1'b0};
            fetch_word_next = bus.Redirect_PC[31:2];
            skip_half_next  = bus.Redirect_PC[1];
            // a response landing in the redirect cycle is simply discarded
            if (state == ST_WAIT) begin
                state_next = bus.Mem_Valid ? ST_FETCH : ST_DROP;
            end else if ((state == ST_DROP) && bus.Mem_Valid) begin
                state_next = ST_FETCH;
            end
        end else begin
            queue_next = shifted;
            if (append) begin
                case (remaining)
                    2'd0: begin
                        if (skip_half) queue_next[15:0]  = bus.Mem_Rdata[31:16];
                        else           queue_next[31:0]  = bus.Mem_Rdata;
                    end
                    2'd1: begin
                        if (skip_half) queue_next[31:16] = bus.Mem_Rdata[31:16];
                        else           queue_next[47:16] = bus.Mem_Rdata;
                    end
                    default: queue_next[47:32] = bus.Mem_Rdata[31:16];
                endcase
            end
            count_next = remaining + appended;

            if (consume) begin
                inst_pc_next = inst_pc + (compr ? 32'd2 : 32'd4);
            end

            case (state)
                ST_FETCH: begin
                    if (mem_req) begin
                        state_next      = ST_WAIT;
                        fetch_word_next = fetch_word + 30'd1;
                    end
                end
                ST_WAIT: begin
                    if (bus.Mem_Valid) begin
                        state_next     = ST_FETCH;
                        skip_half_next = 1'b0;
                    end
                end
                ST_DROP: begin
                    if (bus.Mem_Valid) state_next = ST_FETCH;
                end
                default: state_next = ST_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_aligner.sv
// +--------------------------------------------------------------------+
// | tb_fetch_aligner : memory model + instruction-stream scoreboard     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_aligner_if bus();

    fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        compr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];

    int          checks   = 0;
    int          failures = 0;
    int          lat      = 1;
    int          n_gen    = 6;

    logic        pend       = 1'b0;
    logic        pend_stale = 1'b0;
    int          pend_cnt   = 0;
    logic [31:0] pend_addr  = '0;
    logic [31:0] exp_fetch  = '0;

    logic        last_req, last_valid;
    logic [31:0] last_addr, last_out, last_pc;
    logic        found;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h, want %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0000_0013;
    endfunction

    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem_rd({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // ISA-level walk of memory from a start PC: the instruction stream a core would see
    task automatic gen_exp(input logic [31:0] start);
        logic [31:0] pc;
        logic [15:0] lo;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n_gen; i++) begin
            lo   = mem_hw(pc);
            e.pc = pc;
            if (lo[1:0] != 2'b11) begin
                e.inst  = {16'h0000, lo};
                e.compr = 1'b1;
                pc      = pc + 32'd2;
            end else begin
                e.inst  = {mem_hw(pc + 32'd2), lo};
                e.compr = 1'b0;
                pc      = pc + 32'd4;
            end
            exp_q.push_back(e);
        end
    endtask

    // one clock cycle, entered and left at the falling edge
    task automatic cycle(input logic r, input logic stl, input logic rd, input logic [31:0] rpc);
        exp_t e;
        bus.Mem_Valid = 1'b0;
        bus.Mem_Rdata = 32'h0;
        if (pend) begin
            if (pend_cnt == 0) begin
                bus.Mem_Valid = 1'b1;
                bus.Mem_Rdata = pend_stale ? 32'hDEAD_BEEF : mem_rd(pend_addr);
                pend          = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        rst             = r;
        bus.Stall       = stl;
        bus.Redirect    = rd;
        bus.Redirect_PC = rpc;
        #1;
        last_req   = bus.Mem_Req;
        last_addr  = bus.Mem_Addr;
        last_valid = bus.Inst_Valid;
        last_out   = bus.Inst_Out;
        last_pc    = bus.Inst_PC;

        if (r) begin
            check_eq("rst_mem_req",    32'(bus.Mem_Req), 32'd0);
            check_eq("rst_inst_valid", 32'(bus.Inst_Valid), 32'd0);
        end else begin
            if (rd) begin
                check_eq("redir_inst_valid", 32'(bus.Inst_Valid), 32'd0);
                check_eq("redir_mem_req",    32'(bus.Mem_Req), 32'd0);
            end
            if (bus.Mem_Req) begin
                check_eq("one_outstanding", 32'(pend), 32'd0);
                check_eq("mem_addr", bus.Mem_Addr, exp_fetch);
                exp_fetch  = exp_fetch + 32'd4;
                pend       = 1'b1;
                pend_cnt   = lat - 1;
                pend_addr  = bus.Mem_Addr;
                pend_stale = 1'b0;
            end
            if (bus.Inst_Valid && !stl) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_inst", 32'(bus.Inst_Valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("inst_out",   bus.Inst_Out, e.inst);
                    check_eq("inst_pc",    bus.Inst_PC, e.pc);
                    check_eq("inst_compr", 32'(bus.Inst_Compr), 32'(e.compr));
                end
            end
        end

        if (r || rd) begin
            if (pend) begin
                pend_stale = 1'b1;
                if (r) pend_cnt = 0;
            end
            exp_q.delete();
            if (r) begin
                gen_exp(RESET_PC);
                exp_fetch = {RESET_PC[31:2], 2'b00};
            end else begin
                gen_exp({rpc[31:1], 1'b0});
                exp_fetch = {rpc[31:2], 2'b00};
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input int stall_pct);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, (exp_q.size() == 0) || (int'($urandom_range(99, 0)) < stall_pct),
                  1'b0, 32'h0);
        end
        check_eq("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.Mem_Valid   = 1'b0;
        bus.Mem_Rdata   = 32'h0;
        bus.Redirect    = 1'b0;
        bus.Redirect_PC = 32'h0;
        bus.Stall       = 1'b0;
        @(negedge clk);

        // two 32-bit instructions, 1-cycle memory
        mem.delete();
        mem[32'h0] = 32'h00A0_0093;
        mem[32'h4] = 32'h0010_0113;
        lat = 1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("reset_inst_pc",    last_pc, RESET_PC);
        check_eq("reset_inst_valid", 32'(last_valid), 32'd0);
        check_eq("reset_first_req",  32'(last_req), 32'd1);
        check_eq("reset_first_addr", last_addr, 32'h0);
        run(40, 0);

        // compressed + straddling 32-bit, random stalls, 2-cycle memory
        mem.delete();
        mem[32'h0] = 32'h0093_4505;
        mem[32'h4] = 32'h4505_0010;
        lat = 2;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run(60, 30);

        // redirect to a halfword-offset PC: low half of the first word is skipped
        mem[32'h100] = 32'h0513_FFFF;
        mem[32'h104] = 32'h0001_0000;
        lat = 1;
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0102);
        run(40, 0);

        // redirect while the request to 0x8 is in flight; stale data must vanish
        mem.delete();
        mem[32'h200] = 32'h0010_0113;
        mem[32'h204] = 32'h4505_0001;
        lat = 3;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, exp_q.size() == 0, 1'b0, 32'h0);
            found = last_req && (last_addr == 32'h8);
        end
        check_eq("saw_req_to_8", 32'(found), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        run(50, 0);

        // long stall with a full queue; bit 0 of the redirect PC is ignored
        mem[32'h300] = 32'h0001_4505;
        mem[32'h304] = 32'h00A0_0093;
        lat = 1;
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0303);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            check_eq("stall_inst_out",   last_out, 32'h0000_0001);
            check_eq("stall_inst_pc",    last_pc, 32'h0000_0302);
            check_eq("stall_inst_valid", 32'(last_valid), 32'd1);
            check_eq("stall_mem_req",    32'(last_req), 32'd0);
        end
        run(40, 0);

        // reset while a request is outstanding; the late response must be ignored
        mem.delete();
        mem[32'h0] = 32'h0093_4505;
        mem[32'h4] = 32'h4505_0010;
        lat = 3;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("wait_req_issued", 32'(last_req), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("post_rst_valid",  32'(last_valid), 32'd0);
        check_eq("post_rst_pc",     last_pc, RESET_PC);
        check_eq("post_rst_req",    32'(last_req), 32'd1);
        check_eq("post_rst_addr",   last_addr, {RESET_PC[31:2], 2'b00});
        run(60, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
